// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the two-port memory arbiter: word type, FSM states and latched request.
package mem_port_arbiter_pkg;

  typedef logic [15:0] lc3b_word;

  typedef enum logic [1:0] {
    ArbIdle,
    ArbIssue,
    ArbResp
  } lc3b_arb_state;

  typedef enum logic {
    PortA = 1'b0,
    PortB = 1'b1
  } lc3b_port;

  typedef struct packed {
    lc3b_word   addr;
    lc3b_word   wdata;
    logic [1:0] wmask;
    logic       write;
    lc3b_port   port;
  } lc3b_mem_req;

  // Ties go to the port not granted last (round-robin) or to B (fixed priority).
  function automatic lc3b_port pick_port(logic req_a, logic req_b, logic rr, lc3b_port last);
    if (req_a && req_b) begin
      if (rr) return (last == PortA) ? PortB : PortA;
      return PortB;
    end
    if (req_b) return PortB;
    return PortA;
  endfunction

endpackage

// File: rtl/mem_port_arbiter.sv
// Serialises instruction port A and data port B onto one backing memory port,
// returning a one-cycle response pulse with registered read data to the granted port.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter bit RR_ARB = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_read_a,
  input  logic [15:0] mem_address_a,
  output logic        mem_resp_a,
  output logic [15:0] mem_rdata_a,
  input  logic        mem_read_b,
  input  logic        mem_write_b,
  input  logic [1:0]  mem_wmask_b,
  input  logic [15:0] mem_address_b,
  input  logic [15:0] mem_wdata_b,
  output logic        mem_resp_b,
  output logic [15:0] mem_rdata_b,
  output logic        pmem_read,
  output logic        pmem_write,
  output logic [1:0]  pmem_wmask,
  output logic [15:0] pmem_address,
  output logic [15:0] pmem_wdata,
  input  logic        pmem_resp,
  input  logic [15:0] pmem_rdata
);

  lc3b_arb_state state_q, state_d;
  lc3b_port      last_grant_q, last_grant_d;
  lc3b_mem_req   req_q, req_d;
  logic          pmem_read_q, pmem_read_d;
  logic          pmem_write_q, pmem_write_d;
  logic          mem_resp_a_q, mem_resp_a_d;
  logic          mem_resp_b_q, mem_resp_b_d;
  lc3b_word      mem_rdata_a_q, mem_rdata_a_d;
  lc3b_word      mem_rdata_b_q, mem_rdata_b_d;

  logic     req_a, req_b;
  lc3b_port grant;

  assign req_a = mem_read_a;
  assign req_b = mem_read_b | mem_write_b;
  assign grant = pick_port(req_a, req_b, RR_ARB, last_grant_q);

  always_comb begin
    state_d       = state_q;
    last_grant_d  = last_grant_q;
    req_d         = req_q;
    pmem_read_d   = pmem_read_q;
    pmem_write_d  = pmem_write_q;
    mem_resp_a_d  = 1'b0;
    mem_resp_b_d  = 1'b0;
    mem_rdata_a_d = mem_rdata_a_q;
    mem_rdata_b_d = mem_rdata_b_q;

    unique case (state_q)
      ArbIdle: begin
        if (req_a || req_b) begin
          req_d.port = grant;
          if (grant == PortB) begin
            // Read and write together is treated as a write.
            req_d.addr  = mem_address_b;
            req_d.wdata = mem_wdata_b;
            req_d.write = mem_write_b;
            req_d.wmask = mem_write_b ? mem_wmask_b : 2'b11;
          end else begin
            req_d.addr  = mem_address_a;
            req_d.wdata = '0;
            req_d.write = 1'b0;
            req_d.wmask = 2'b11;
          end
          last_grant_d = grant;
          pmem_read_d  = ~req_d.write;
          pmem_write_d = req_d.write;
          state_d      = ArbIssue;
        end
      end
      ArbIssue: begin
        if (pmem_resp) begin
          if (!req_q.write) begin
            if (req_q.port == PortA) mem_rdata_a_d = pmem_rdata;
            else                     mem_rdata_b_d = pmem_rdata;
          end
          mem_resp_a_d = (req_q.port == PortA);
          mem_resp_b_d = (req_q.port == PortB);
          pmem_read_d  = 1'b0;
          pmem_write_d = 1'b0;
          state_d      = ArbResp;
        end
      end
      ArbResp: begin
        state_d = ArbIdle;
      end
      default: begin
        state_d = ArbIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ArbIdle;
      last_grant_q  <= PortA;
      req_q         <= '0;
      pmem_read_q   <= 1'b0;
      pmem_write_q  <= 1'b0;
      mem_resp_a_q  <= 1'b0;
      mem_resp_b_q  <= 1'b0;
      mem_rdata_a_q <= '0;
      mem_rdata_b_q <= '0;
    end else begin
      state_q       <= state_d;
      last_grant_q  <= last_grant_d;
      req_q         <= req_d;
      pmem_read_q   <= pmem_read_d;
      pmem_write_q  <= pmem_write_d;
      mem_resp_a_q  <= mem_resp_a_d;
      mem_resp_b_q  <= mem_resp_b_d;
      mem_rdata_a_q <= mem_rdata_a_d;
      mem_rdata_b_q <= mem_rdata_b_d;
    end
  end

  // Backing-port fields come straight from the latched request.
  assign pmem_read    = pmem_read_q;
  assign pmem_write   = pmem_write_q;
  assign pmem_address = req_q.addr;
  assign pmem_wdata   = req_q.wdata;
  assign pmem_wmask   = req_q.wmask;
  assign mem_resp_a   = mem_resp_a_q;
  assign mem_resp_b   = mem_resp_b_q;
  assign mem_rdata_a  = mem_rdata_a_q;
  assign mem_rdata_b  = mem_rdata_b_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench: a behavioural backing memory plus a transaction-level model of the
// arbiter drives randomized and directed traffic into round-robin and fixed-priority instances.
module tb_mem_port_arbiter;
  import mem_port_arbiter_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_read_a, mem_read_b, mem_write_b, pmem_resp;
  logic [15:0] mem_address_a, mem_address_b, mem_wdata_b, pmem_rdata;
  logic [1:0]  mem_wmask_b;

  logic        mem_resp_a, mem_resp_b, pmem_read, pmem_write;
  logic [15:0] mem_rdata_a, mem_rdata_b, pmem_address, pmem_wdata;
  logic [1:0]  pmem_wmask;

  logic        mem_resp_a_f, mem_resp_b_f, pmem_read_f, pmem_write_f;
  logic [15:0] mem_rdata_a_f, mem_rdata_b_f, pmem_address_f, pmem_wdata_f;
  logic [1:0]  pmem_wmask_f;

  always #5 clk = ~clk;

  mem_port_arbiter #(.RR_ARB(1'b1)) dut (
    .clk(clk), .reset(reset),
    .mem_read_a(mem_read_a), .mem_address_a(mem_address_a),
    .mem_resp_a(mem_resp_a), .mem_rdata_a(mem_rdata_a),
    .mem_read_b(mem_read_b), .mem_write_b(mem_write_b), .mem_wmask_b(mem_wmask_b),
    .mem_address_b(mem_address_b), .mem_wdata_b(mem_wdata_b),
    .mem_resp_b(mem_resp_b), .mem_rdata_b(mem_rdata_b),
    .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_wmask(pmem_wmask),
    .pmem_address(pmem_address), .pmem_wdata(pmem_wdata),
    .pmem_resp(pmem_resp), .pmem_rdata(pmem_rdata)
  );

  // Shares inputs with dut; only its response order is checked.
  mem_port_arbiter #(.RR_ARB(1'b0)) dut_fp (
    .clk(clk), .reset(reset),
    .mem_read_a(mem_read_a), .mem_address_a(mem_address_a),
    .mem_resp_a(mem_resp_a_f), .mem_rdata_a(mem_rdata_a_f),
    .mem_read_b(mem_read_b), .mem_write_b(mem_write_b), .mem_wmask_b(mem_wmask_b),
    .mem_address_b(mem_address_b), .mem_wdata_b(mem_wdata_b),
    .mem_resp_b(mem_resp_b_f), .mem_rdata_b(mem_rdata_b_f),
    .pmem_read(pmem_read_f), .pmem_write(pmem_write_f), .pmem_wmask(pmem_wmask_f),
    .pmem_address(pmem_address_f), .pmem_wdata(pmem_wdata_f),
    .pmem_resp(pmem_resp), .pmem_rdata(pmem_rdata)
  );

  int vectors = 0;
  int miscompares = 0;

  bit [15:0]   ram [65536];
  int          ph;          // 0 idle, 1 waiting on backing memory, 2 responding
  int          last_port;   // 0 = A, 1 = B
  int          cur_port;
  logic [15:0] cur_addr, cur_wdata, resp_data;
  logic [1:0]  cur_mask;
  bit          cur_wr;
  int          wait_left, fixed_delay;
  bit          stray_en;
  logic [15:0] exp_rdata_a, exp_rdata_b;
  bit          done_a, done_b;
  int          n_grants, n_resps;
  int          main_log[$];
  int          fp_log[$];

  // One clock of the transaction model and backing memory; called at a falling edge.
  task automatic step();
    bit          pa, pb, sb_wr, gave, was_rst;
    logic [15:0] sa_addr, sb_addr, sb_wdata;
    logic [1:0]  sb_mask;
    logic [3:0]  exp_flags;
    int          ph_prev;
    pa = mem_read_a; pb = mem_read_b | mem_write_b; sb_wr = mem_write_b;
    sa_addr = mem_address_a; sb_addr = mem_address_b; sb_wdata = mem_wdata_b;
    sb_mask = mem_wmask_b; gave = pmem_resp; was_rst = reset; ph_prev = ph;
    @(posedge clk);
    @(negedge clk);
    if (mem_resp_a_f === 1'b1) fp_log.push_back(0);
    if (mem_resp_b_f === 1'b1) fp_log.push_back(1);
    if (was_rst) begin
      ph = 0; last_port = 0; exp_rdata_a = '0; exp_rdata_b = '0; pmem_resp = 1'b0;
      vectors++;
      if ({pmem_read, pmem_write, mem_resp_a, mem_resp_b} !== 4'b0000) begin
        miscompares++;
        $display("FAIL reset_flags: got %b want 0000",
                 {pmem_read, pmem_write, mem_resp_a, mem_resp_b});
      end
      return;
    end
    case (ph_prev)
      0:       ph = (pa || pb) ? 1 : 0;
      1:       ph = gave ? 2 : 1;
      default: ph = 0;
    endcase
    if (ph_prev == 0 && ph == 1) begin
      if (pa && pb) cur_port = (last_port == 0) ? 1 : 0;
      else          cur_port = pb ? 1 : 0;
      last_port = cur_port;
      n_grants++;
      if (cur_port == 1) begin
        cur_addr = sb_addr; cur_wr = sb_wr; cur_wdata = sb_wdata;
        cur_mask = sb_wr ? sb_mask : 2'b11;
      end else begin
        cur_addr = sa_addr; cur_wr = 1'b0; cur_wdata = '0; cur_mask = 2'b11;
      end
      wait_left = (fixed_delay > 0) ? fixed_delay : int'($urandom_range(8, 1));
    end
    exp_flags = {ph == 1 && !cur_wr, ph == 1 && cur_wr, ph == 2 && cur_port == 0,
                 ph == 2 && cur_port == 1};
    vectors++;
    if ({pmem_read, pmem_write, mem_resp_a, mem_resp_b} !== exp_flags) begin
      miscompares++;
      $display("FAIL flags{rd,wr,resp_a,resp_b}: got %b want %b at %0t",
               {pmem_read, pmem_write, mem_resp_a, mem_resp_b}, exp_flags, $time);
    end
    if (ph == 1) begin
      vectors++;
      if (pmem_address !== cur_addr || pmem_wmask !== cur_mask ||
          (cur_wr && pmem_wdata !== cur_wdata)) begin
        miscompares++;
        $display("FAIL pmem_fields: got addr %h mask %b wdata %h want addr %h mask %b wdata %h",
                 pmem_address, pmem_wmask, pmem_wdata, cur_addr, cur_mask, cur_wdata);
      end
    end
    if (ph == 2) begin
      if (!cur_wr) begin
        if (cur_port == 0) exp_rdata_a = resp_data;
        else               exp_rdata_b = resp_data;
      end
      vectors++;
      if ({mem_rdata_a, mem_rdata_b} !== {exp_rdata_a, exp_rdata_b}) begin
        miscompares++;
        $display("FAIL rdata: got a=%h b=%h want a=%h b=%h",
                 mem_rdata_a, mem_rdata_b, exp_rdata_a, exp_rdata_b);
      end
      n_resps++;
      main_log.push_back(cur_port);
      if (cur_port == 0) done_a = 1'b1;
      else               done_b = 1'b1;
    end
    pmem_resp = 1'b0;
    pmem_rdata = 16'($urandom);
    if (ph == 1) begin
      if (wait_left == 1) begin
        pmem_resp = 1'b1;
        if (pmem_write) begin
          if (pmem_wmask[1]) ram[pmem_address][15:8] = pmem_wdata[15:8];
          if (pmem_wmask[0]) ram[pmem_address][7:0] = pmem_wdata[7:0];
        end else begin
          resp_data = ram[pmem_address];
          pmem_rdata = resp_data;
        end
      end
      wait_left--;
    end else if (stray_en && $urandom_range(7, 0) == 0) begin
      pmem_resp = 1'b1;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1; mem_read_a = 1'b0; mem_read_b = 1'b0; mem_write_b = 1'b0;
    pmem_resp = 1'b0;
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    repeat (10) step();
    vectors++;
    if ({pmem_wmask, pmem_address, pmem_wdata, mem_rdata_a, mem_rdata_b} !== 66'd0) begin
      miscompares++;
      $display("FAIL reset_values: got wmask %b addr %h wdata %h ra %h rb %h want all zero",
               pmem_wmask, pmem_address, pmem_wdata, mem_rdata_a, mem_rdata_b);
    end
    vectors++;
    if (dut.state_q !== ArbIdle) begin
      miscompares++;
      $display("FAIL reset_state: got %0d want %0d", dut.state_q, ArbIdle);
    end
  endtask

  task automatic test_read_a();
    int n = 0;
    fixed_delay = 2; ram[16'h0040] = 16'h1234;
    mem_address_a = 16'h0040; mem_read_a = 1'b1; done_a = 1'b0;
    while (!done_a && n < 20) begin step(); n++; end
    mem_read_a = 1'b0;
    vectors++;
    if (!done_a || n != 3) begin
      miscompares++;
      $display("FAIL read_a_latency: got %0d cycles (done=%0d) want 3", n, done_a);
    end
    vectors++;
    if (mem_rdata_a !== 16'h1234) begin
      miscompares++;
      $display("FAIL read_a_data: got %h want 1234", mem_rdata_a);
    end
    repeat (2) step();
  endtask

  task automatic test_write_b();
    int n = 0;
    fixed_delay = 1; ram[16'h0200] = 16'h5A5A;
    mem_address_b = 16'h0200; mem_read_b = 1'b1; done_b = 1'b0;
    while (!done_b && n < 20) begin step(); n++; end
    mem_read_b = 1'b0;
    step();
    fixed_delay = 3; ram[16'h0101] = 16'h00CD; n = 0;
    mem_address_b = 16'h0101; mem_wmask_b = 2'b10; mem_wdata_b = 16'hAB00;
    mem_write_b = 1'b1; done_b = 1'b0;
    while (!done_b && n < 20) begin step(); n++; end
    mem_write_b = 1'b0;
    vectors++;
    if (!done_b || n != 4) begin
      miscompares++;
      $display("FAIL write_b_latency: got %0d cycles (done=%0d) want 4", n, done_b);
    end
    vectors++;
    if (ram[16'h0101] !== 16'hABCD) begin
      miscompares++;
      $display("FAIL write_b_memory: got %h want abcd", ram[16'h0101]);
    end
    vectors++;
    if (mem_rdata_b !== 16'h5A5A) begin
      miscompares++;
      $display("FAIL write_b_rdata_kept: got %h want 5a5a", mem_rdata_b);
    end
    repeat (2) step();
  endtask

  task automatic test_arb_pair();
    int n = 0;
    do_reset();
    fixed_delay = 1;
    main_log.delete(); fp_log.delete();
    mem_address_a = 16'h0010; mem_address_b = 16'h0020;
    mem_read_a = 1'b1; mem_read_b = 1'b1; mem_write_b = 1'b0;
    while (main_log.size() < 2 && n < 30) begin step(); n++; end
    mem_read_a = 1'b0; mem_read_b = 1'b0;
    repeat (3) step();
    vectors++;
    if (main_log.size() < 2 || main_log[0] != 1 || main_log[1] != 0) begin
      miscompares++;
      $display("FAIL rr_order: got %p want '{1, 0} (1=B)", main_log);
    end
    vectors++;
    if (fp_log.size() < 2 || fp_log[0] != 1 || fp_log[1] != 1) begin
      miscompares++;
      $display("FAIL fixed_order: got %p want '{1, 1} (1=B)", fp_log);
    end
  endtask

  task automatic test_reset_mid();
    fixed_delay = 8;
    mem_address_a = 16'h0077; mem_read_a = 1'b1;
    step();
    reset = 1'b1; mem_read_a = 1'b0;
    step();
    reset = 1'b0; pmem_resp = 1'b1; pmem_rdata = 16'hDEAD;
    step();
    step();
    vectors++;
    if (dut.state_q !== ArbIdle || mem_rdata_a !== 16'h0000) begin
      miscompares++;
      $display("FAIL reset_mid: got state %0d rdata_a %h want state %0d rdata_a 0000",
               dut.state_q, mem_rdata_a, ArbIdle);
    end
  endtask

  task automatic test_random();
    int g0, r0, cycles;
    fixed_delay = 0; stray_en = 1'b1;
    g0 = n_grants; r0 = n_resps; cycles = 0;
    while (n_resps - r0 < 500 && cycles < 20000) begin
      if (!mem_read_a && $urandom_range(2, 0) == 0) begin
        mem_address_a = 16'($urandom); mem_read_a = 1'b1;
      end
      if (!(mem_read_b || mem_write_b) && $urandom_range(2, 0) == 0) begin
        int k = int'($urandom_range(9, 0));
        mem_address_b = 16'($urandom); mem_wdata_b = 16'($urandom);
        mem_wmask_b = 2'($urandom);
        mem_read_b = (k < 5) || (k == 9); mem_write_b = (k >= 5);
      end
      // Changes after grant must not reach the backing port.
      if (ph == 1 && $urandom_range(3, 0) == 0) begin
        if (cur_port == 0) mem_address_a = 16'($urandom);
        else begin mem_address_b = 16'($urandom); mem_wdata_b = 16'($urandom); end
      end
      step();
      cycles++;
      if (done_a) begin
        done_a = 1'b0;
        if ($urandom_range(1, 0) == 0) mem_read_a = 1'b0;
        else mem_address_a = 16'($urandom);
      end
      if (done_b) begin
        done_b = 1'b0;
        if ($urandom_range(1, 0) == 0) begin mem_read_b = 1'b0; mem_write_b = 1'b0; end
        else begin mem_address_b = 16'($urandom); mem_wdata_b = 16'($urandom); end
      end
    end
    mem_read_a = 1'b0; mem_read_b = 1'b0; mem_write_b = 1'b0;
    repeat (15) step();
    stray_en = 1'b0;
    vectors++;
    if (n_resps - r0 < 500) begin
      miscompares++;
      $display("FAIL random_timeout: got %0d responses want 500", n_resps - r0);
    end
    vectors++;
    if (n_grants - g0 != n_resps - r0) begin
      miscompares++;
      $display("FAIL random_resp_count: got %0d responses want %0d (one per grant)",
               n_resps - r0, n_grants - g0);
    end
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) ram[i] = 16'($urandom);
    reset = 1'b1; mem_read_a = 1'b0; mem_read_b = 1'b0; mem_write_b = 1'b0;
    mem_address_a = '0; mem_address_b = '0; mem_wdata_b = '0; mem_wmask_b = '0;
    pmem_resp = 1'b0; pmem_rdata = '0;
    ph = 0; last_port = 0; cur_port = 0; cur_wr = 1'b0; cur_addr = '0; cur_wdata = '0;
    cur_mask = 2'b11; resp_data = '0; wait_left = 0; fixed_delay = 1; stray_en = 1'b0;
    exp_rdata_a = '0; exp_rdata_b = '0; done_a = 1'b0; done_b = 1'b0;
    n_grants = 0; n_resps = 0;
    test_reset();
    test_read_a();
    test_write_b();
    test_arb_pair();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
